// File: rtl/ws_sram_writer_if.sv
// Bus bundle for the Write-S stage: start/done handshake, block geometry,
// S DPRAM read port and external SRAM write port.
interface ws_sram_writer_if #(
  parameter int unsigned RAM_AW = 7
);
  logic              WS_start;
  logic              WS_done;
  logic [17:0]       base_address;
  logic [8:0]        row_words;
  logic [4:0]        block_row;
  logic [5:0]        block_col;
  logic [RAM_AW-1:0] RAM_address;
  logic [31:0]       RAM_read_data;
  logic [17:0]       SRAM_address;
  logic [15:0]       SRAM_write_data;
  logic              SRAM_we_n;

  modport master (
    output WS_start, base_address, row_words, block_row, block_col,
    output RAM_read_data,
    input  WS_done, RAM_address, SRAM_address, SRAM_write_data, SRAM_we_n
  );

  modport slave (
    input  WS_start, base_address, row_words, block_row, block_col,
    input  RAM_read_data,
    output WS_done, RAM_address, SRAM_address, SRAM_write_data, SRAM_we_n
  );
endinterface

// File: rtl/ws_sram_writer.sv
// Write-S stage: reads an 8x8 block of signed S values, clips to 0..255,
// packs column pairs and writes 32 words to the Y/U/V SRAM segment.
module ws_sram_writer #(
  parameter int unsigned RAM_AW     = 7,
  parameter int unsigned RAM_OFFSET = 0
) (
  input  logic                 CLOCK_50_I,
  input  logic                 Resetn,
  ws_sram_writer_if.slave      bus
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } state_e;

  state_e            state_q;
  logic [6:0]        cnt_q;
  logic [RAM_AW-1:0] ram_addr_q;
  logic [17:0]       row_ptr_q;
  logic [8:0]        row_words_q;
  logic [7:0]        even_q;
  logic [17:0]       sram_addr_q;
  logic [15:0]       sram_data_q;
  logic              we_n_q;
  logic              done_q;

  logic              data_vld;
  logic [5:0]        k;
  logic [7:0]        clip_byte;
  logic [17:0]       pair_addr;
  logic [17:0]       prod;
  logic [17:0]       start_ptr;

  // cnt_q counts cycles since the first RAM address; data for index cnt_q-1
  // is on RAM_read_data because of the one-cycle read latency.
  always_comb begin
    data_vld  = ((state_q == READ) && (cnt_q != 7'd0)) ||
                ((state_q == DRAIN) && (cnt_q == 7'd64));
    k         = 6'(cnt_q - 7'd1);
    if (bus.RAM_read_data[31])
      clip_byte = 8'h00;
    else if (|bus.RAM_read_data[30:8])
      clip_byte = 8'hFF;
    else
      clip_byte = bus.RAM_read_data[7:0];
    pair_addr = row_ptr_q + {16'd0, k[2:1]};
    // The only multiply is a one-shot at start; per-row advance is an add.
    prod      = 18'({10'd0, bus.block_row, 3'b000} * {9'd0, bus.row_words});
    start_ptr = bus.base_address + prod + {10'd0, bus.block_col, 2'b00};
  end

  always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
    if (!Resetn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ram_addr_q  <= '0;
      row_ptr_q   <= '0;
      row_words_q <= '0;
      even_q      <= '0;
      sram_addr_q <= '0;
      sram_data_q <= '0;
      we_n_q      <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      we_n_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (bus.WS_start) begin
            row_ptr_q   <= start_ptr;
            row_words_q <= bus.row_words;
            cnt_q       <= '0;
            ram_addr_q  <= RAM_AW'(RAM_OFFSET);
            state_q     <= READ;
          end
        end
        READ: begin
          cnt_q <= cnt_q + 7'd1;
          if (cnt_q == 7'd63)
            state_q <= DRAIN;
          else
            ram_addr_q <= ram_addr_q + RAM_AW'(1);
        end
        DRAIN: begin
          cnt_q <= cnt_q + 7'd1;
          if (cnt_q == 7'd65) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase

      if (data_vld) begin
        if (!k[0]) begin
          even_q <= clip_byte;
        end else begin
          we_n_q      <= 1'b0;
          sram_addr_q <= pair_addr;
          sram_data_q <= {even_q, clip_byte};
          if (k[2:0] == 3'd7)
            row_ptr_q <= row_ptr_q + {9'd0, row_words_q};
        end
      end
    end
  end

  assign bus.WS_done         = done_q;
  assign bus.RAM_address     = ram_addr_q;
  assign bus.SRAM_address    = sram_addr_q;
  assign bus.SRAM_write_data = sram_data_q;
  assign bus.SRAM_we_n       = we_n_q;

endmodule

// File: tb/tb_ws_sram_writer.sv
// Scoreboard bench for ws_sram_writer: a behavioural S RAM feeds the DUT and
// expected SRAM writes (address, data, cycle) are queued and popped per block.
module tb_ws_sram_writer;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #10 clk = ~clk;

  ws_sram_writer_if #(.RAM_AW(7)) bus ();

  ws_sram_writer #(.RAM_AW(7), .RAM_OFFSET(0)) dut (
    .CLOCK_50_I (clk),
    .Resetn     (rstn),
    .bus        (bus)
  );

  logic [31:0] mem [0:127];
  always @(posedge clk) bus.RAM_read_data <= mem[bus.RAM_address];

  typedef struct {
    logic [17:0] addr;
    logic [15:0] data;
    int          m;
  } wr_t;

  wr_t        exp_q[$];
  wr_t        obs_q[$];
  int         done_seen[$];
  logic [6:0] ram_seq[$];

  logic        snap_done, snap_we_n;
  logic [17:0] snap_addr;
  logic [15:0] snap_data;
  logic [6:0]  snap_ram;

  int tests_run    = 0;
  int tests_failed = 0;

  function automatic logic [7:0] clip8(input logic [31:0] v);
    int s;
    s = v;
    if (s < 0)   return 8'd0;
    if (s > 255) return 8'd255;
    return 8'(s);
  endfunction

  // Expected writes for one block; m0 is the start cycle offset of the block.
  task automatic push_block(input logic [17:0] base, input logic [8:0] rw,
                            input logic [4:0] brow, input logic [5:0] bcol,
                            input int m0);
    for (int r = 0; r < 8; r++) begin
      for (int j = 0; j < 4; j++) begin
        wr_t w;
        int unsigned a;
        a = int'(base) + (int'(brow) * 8 + r) * int'(rw) + int'(bcol) * 4 + j;
        w.addr = 18'(a);
        w.data = {clip8(mem[8*r+2*j]), clip8(mem[8*r+2*j+1])};
        w.m    = m0 + 8*r + 2*j + 4;
        exp_q.push_back(w);
      end
    end
  endtask

  // Starts a block and records DUT activity for a fixed number of cycles.
  task automatic run_block(input logic [17:0] base, input logic [8:0] rw,
                           input logic [4:0] brow, input logic [5:0] bcol,
                           input int cycles, input int release_at,
                           input int pulse_at, input int reset_at,
                           input bit scramble);
    wr_t w;
    obs_q.delete();
    done_seen.delete();
    ram_seq.delete();
    bus.base_address = base;
    bus.row_words    = rw;
    bus.block_row    = brow;
    bus.block_col    = bcol;
    bus.WS_start     = 1'b1;
    for (int m = 1; m <= cycles; m++) begin
      @(negedge clk);
      if (bus.SRAM_we_n === 1'b0) begin
        w.addr = bus.SRAM_address;
        w.data = bus.SRAM_write_data;
        w.m    = m;
        obs_q.push_back(w);
      end
      if (bus.WS_done === 1'b1) done_seen.push_back(m);
      if (m <= 64) ram_seq.push_back(bus.RAM_address);
      bus.WS_start = (m < release_at) || (m == pulse_at);
      if (scramble && m == 2) begin
        bus.base_address = 18'($urandom);
        bus.row_words    = 9'($urandom);
        bus.block_row    = 5'($urandom);
        bus.block_col    = 6'($urandom);
      end
      if (m == reset_at) begin
        rstn = 1'b0;
        bus.WS_start = 1'b0;
        #1;
        snap_done = bus.WS_done;
        snap_we_n = bus.SRAM_we_n;
        snap_addr = bus.SRAM_address;
        snap_data = bus.SRAM_write_data;
        snap_ram  = bus.RAM_address;
      end
      if (reset_at > 0 && m == reset_at + 3) rstn = 1'b1;
    end
    bus.WS_start = 1'b0;
  endtask

  task automatic test_reset;
    bus.WS_start = 1'b0;
    bus.base_address = '0;
    bus.row_words = '0;
    bus.block_row = '0;
    bus.block_col = '0;
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if (bus.WS_done !== 1'b0) begin
      tests_failed++; $display("FAIL reset_done got %b want 0", bus.WS_done);
    end
    tests_run++;
    if (bus.SRAM_we_n !== 1'b1) begin
      tests_failed++; $display("FAIL reset_we_n got %b want 1", bus.SRAM_we_n);
    end
    tests_run++;
    if (bus.SRAM_address !== 18'd0) begin
      tests_failed++; $display("FAIL reset_sram_addr got %0d want 0", bus.SRAM_address);
    end
    tests_run++;
    if (bus.SRAM_write_data !== 16'd0) begin
      tests_failed++; $display("FAIL reset_sram_data got %h want 0000", bus.SRAM_write_data);
    end
    tests_run++;
    if (bus.RAM_address !== 7'd0) begin
      tests_failed++; $display("FAIL reset_ram_addr got %0d want 0", bus.RAM_address);
    end
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if (bus.SRAM_we_n !== 1'b1 || bus.WS_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_quiet got we_n=%b done=%b want we_n=1 done=0", bus.SRAM_we_n, bus.WS_done);
    end
  endtask

  task automatic test_y_block;
    for (int i = 0; i < 64; i++) mem[i] = 32'(i);
    exp_q.delete();
    push_block(18'd0, 9'd160, 5'd0, 6'd0, 0);
    run_block(18'd0, 9'd160, 5'd0, 6'd0, 80, 1, 0, 0, 1'b1);
    tests_run++;
    if (obs_q.size() != 32) begin
      tests_failed++; $display("FAIL y_count got %0d want 32", obs_q.size());
    end else begin
      tests_run++;
      if (obs_q[0].addr !== 18'd0 || obs_q[0].data !== 16'h0001) begin
        tests_failed++;
        $display("FAIL y_first got %0d/%h want 0/0001", obs_q[0].addr, obs_q[0].data);
      end
      tests_run++;
      if (obs_q[31].addr !== 18'd1123 || obs_q[31].data !== 16'h3E3F) begin
        tests_failed++;
        $display("FAIL y_last got %0d/%h want 1123/3e3f", obs_q[31].addr, obs_q[31].data);
      end
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      wr_t e, o;
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      tests_run++;
      if (o.addr !== e.addr || o.data !== e.data || o.m != e.m) begin
        tests_failed++;
        $display("FAIL y_write got %0d/%h@%0d want %0d/%h@%0d", o.addr, o.data, o.m, e.addr, e.data, e.m);
      end
    end
    tests_run++;
    if (done_seen.size() != 1 || done_seen[0] != 67) begin
      tests_failed++;
      $display("FAIL y_done got %0d pulses first@%0d want 1@67", done_seen.size(),
               (done_seen.size() > 0) ? done_seen[0] : -1);
    end
  endtask

  task automatic test_clip;
    logic [31:0] row0 [0:7];
    row0 = '{32'hFFFF_FFFF, 32'd256, 32'd255, 32'd0,
             32'h8000_0000, 32'h7FFF_FFFF, 32'd300, 32'd128};
    for (int i = 0; i < 8; i++) mem[i] = row0[i];
    for (int i = 8; i < 64; i++)
      mem[i] = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
    exp_q.delete();
    push_block(18'd100, 9'd160, 5'd2, 6'd5, 0);
    run_block(18'd100, 9'd160, 5'd2, 6'd5, 80, 1, 0, 0, 1'b1);
    if (obs_q.size() >= 4) begin
      tests_run++;
      if (obs_q[0].data !== 16'h00FF || obs_q[1].data !== 16'hFF00 ||
          obs_q[2].data !== 16'h00FF || obs_q[3].data !== 16'hFF80) begin
        tests_failed++;
        $display("FAIL clip_row0 got %h %h %h %h want 00ff ff00 00ff ff80",
                 obs_q[0].data, obs_q[1].data, obs_q[2].data, obs_q[3].data);
      end
    end else begin
      tests_run++; tests_failed++;
      $display("FAIL clip_count got %0d want 32", obs_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      wr_t e, o;
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      tests_run++;
      if (o.addr !== e.addr || o.data !== e.data || o.m != e.m) begin
        tests_failed++;
        $display("FAIL clip_write got %0d/%h@%0d want %0d/%h@%0d", o.addr, o.data, o.m, e.addr, e.data, e.m);
      end
    end
  endtask

  task automatic test_u_block;
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    exp_q.delete();
    push_block(18'd38400, 9'd80, 5'd29, 6'd19, 0);
    run_block(18'd38400, 9'd80, 5'd29, 6'd19, 80, 1, 0, 0, 1'b1);
    tests_run++;
    if (obs_q.size() != 32) begin
      tests_failed++; $display("FAIL u_count got %0d want 32", obs_q.size());
    end else begin
      tests_run++;
      if (18'(obs_q[31].addr - obs_q[0].addr) !== 18'd563) begin
        tests_failed++;
        $display("FAIL u_span got %0d want 563", 18'(obs_q[31].addr - obs_q[0].addr));
      end
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      wr_t e, o;
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      tests_run++;
      if (o.addr !== e.addr || o.data !== e.data || o.m != e.m) begin
        tests_failed++;
        $display("FAIL u_write got %0d/%h@%0d want %0d/%h@%0d", o.addr, o.data, o.m, e.addr, e.data, e.m);
      end
    end
  endtask

  task automatic test_timing;
    int consec;
    int bad_ram;
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    exp_q.delete();
    push_block(18'd5000, 9'd160, 5'd3, 6'd7, 0);
    run_block(18'd5000, 9'd160, 5'd3, 6'd7, 110, 1, 30, 0, 1'b0);
    tests_run++;
    if (obs_q.size() != 32) begin
      tests_failed++; $display("FAIL timing_count got %0d want 32", obs_q.size());
    end
    consec = 0;
    for (int i = 1; i < obs_q.size(); i++)
      if (obs_q[i].m == obs_q[i-1].m + 1) consec++;
    tests_run++;
    if (consec != 0) begin
      tests_failed++; $display("FAIL timing_consecutive got %0d want 0", consec);
    end
    bad_ram = 0;
    for (int i = 0; i < ram_seq.size(); i++)
      if (ram_seq[i] !== 7'(i)) bad_ram++;
    tests_run++;
    if (bad_ram != 0 || ram_seq.size() != 64) begin
      tests_failed++;
      $display("FAIL timing_ram_seq got %0d bad of %0d want 0 of 64", bad_ram, ram_seq.size());
    end
    tests_run++;
    if (done_seen.size() != 1 || done_seen[0] != 67) begin
      tests_failed++;
      $display("FAIL timing_done got %0d pulses first@%0d want 1@67", done_seen.size(),
               (done_seen.size() > 0) ? done_seen[0] : -1);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      wr_t e, o;
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      tests_run++;
      if (o.addr !== e.addr || o.data !== e.data || o.m != e.m) begin
        tests_failed++;
        $display("FAIL timing_write got %0d/%h@%0d want %0d/%h@%0d", o.addr, o.data, o.m, e.addr, e.data, e.m);
      end
    end
  endtask

  task automatic test_reset_abort;
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    exp_q.delete();
    push_block(18'd700, 9'd160, 5'd1, 6'd2, 0);
    run_block(18'd700, 9'd160, 5'd1, 6'd2, 90, 1, 0, 30, 1'b0);
    tests_run++;
    if (snap_done !== 1'b0 || snap_we_n !== 1'b1 || snap_addr !== 18'd0 ||
        snap_data !== 16'd0 || snap_ram !== 7'd0) begin
      tests_failed++;
      $display("FAIL abort_outputs got done=%b we_n=%b sa=%0d sd=%h ra=%0d want 0 1 0 0000 0",
               snap_done, snap_we_n, snap_addr, snap_data, snap_ram);
    end
    tests_run++;
    if (obs_q.size() != 14 || done_seen.size() != 0) begin
      tests_failed++;
      $display("FAIL abort_activity got %0d writes %0d dones want 14 writes 0 dones",
               obs_q.size(), done_seen.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      wr_t e, o;
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      tests_run++;
      if (o.addr !== e.addr || o.data !== e.data || o.m != e.m) begin
        tests_failed++;
        $display("FAIL abort_partial got %0d/%h@%0d want %0d/%h@%0d", o.addr, o.data, o.m, e.addr, e.data, e.m);
      end
    end
    exp_q.delete();
    push_block(18'd900, 9'd80, 5'd4, 6'd9, 0);
    run_block(18'd900, 9'd80, 5'd4, 6'd9, 80, 1, 0, 0, 1'b0);
    tests_run++;
    if (obs_q.size() != 32 || done_seen.size() != 1) begin
      tests_failed++;
      $display("FAIL abort_restart got %0d writes %0d dones want 32 1", obs_q.size(), done_seen.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      wr_t e, o;
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      tests_run++;
      if (o.addr !== e.addr || o.data !== e.data || o.m != e.m) begin
        tests_failed++;
        $display("FAIL abort_restart_write got %0d/%h@%0d want %0d/%h@%0d", o.addr, o.data, o.m, e.addr, e.data, e.m);
      end
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    exp_q.delete();
    push_block(18'd2000, 9'd160, 5'd6, 6'd11, 0);
    push_block(18'd2000, 9'd160, 5'd6, 6'd11, 68);
    run_block(18'd2000, 9'd160, 5'd6, 6'd11, 150, 100, 0, 0, 1'b0);
    tests_run++;
    if (obs_q.size() != 64) begin
      tests_failed++; $display("FAIL b2b_count got %0d want 64", obs_q.size());
    end else begin
      tests_run++;
      if (obs_q[32].m - obs_q[0].m != 68) begin
        tests_failed++; $display("FAIL b2b_period got %0d want 68", obs_q[32].m - obs_q[0].m);
      end
    end
    tests_run++;
    if (done_seen.size() != 2 || done_seen[0] != 67 || done_seen[1] != 135) begin
      tests_failed++;
      $display("FAIL b2b_done got %0d pulses want 2 at 67 and 135", done_seen.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      wr_t e, o;
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      tests_run++;
      if (o.addr !== e.addr || o.data !== e.data || o.m != e.m) begin
        tests_failed++;
        $display("FAIL b2b_write got %0d/%h@%0d want %0d/%h@%0d", o.addr, o.data, o.m, e.addr, e.data, e.m);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = '0;
    test_reset();
    test_y_block();
    test_clip();
    test_u_block();
    test_timing();
    test_reset_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
